// File: rtl/mult_div_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The requester drives start/op/operands; the unit returns status and results.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dbz;

  modport master (
    output start, op, op_a, op_b,
    input  busy, done, hi, lo, dbz
  );

  modport slave (
    input  start, op, op_a, op_b,
    output busy, done, hi, lo, dbz
  );
endinterface

// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply (shift-add) and divide (restoring) unit.
// Signed ops run on magnitudes; signs are re-applied in the FIX state.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mult_div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_q, div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dbz_q, dbz_d;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               busy, done;

  assign accept = bus.start &
                  ((state_q == IDLE) | (state_q == DONE));

  assign a_neg = bus.op[0] & bus.op_a[WIDTH-1];
  assign b_neg = bus.op[0] & bus.op_b[WIDTH-1];
  assign a_mag = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag = b_neg ? -bus.op_b : bus.op_b;

  // low_q holds the multiplier (consumed LSB first) or the
  // dividend (consumed MSB first) and fills with result bits.
  assign mul_sum = {1'b0, acc_q} +
                   (low_q[0] ? {1'b0, b_q} : '0);
  assign div_sh  = {acc_q, low_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, b_q};

  assign prod     = {acc_q, low_q};
  assign prod_fix = neg_lo_q ? -prod : prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = CALC;
      CALC: if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = bus.start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC) | (state_q == FIX);
    done = (state_q == DONE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    low_d    = low_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dbz_d    = dbz_q;
    if (accept) begin
      cnt_d    = '0;
      acc_d    = '0;
      low_d    = a_mag;
      b_d      = b_mag;
      div_d    = bus.op[1];
      dbz_d    = 1'b0;
      // A zero divisor must yield an all-ones quotient unsigned.
      neg_lo_d = (a_neg ^ b_neg) &
                 ~(bus.op[1] & (bus.op_b == '0));
      neg_hi_d = bus.op[1] & a_neg;
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + CW'(1);
      if (div_q) begin
        acc_d = div_ge ? WIDTH'(div_sh - {1'b0, b_q})
                       : div_sh[WIDTH-1:0];
        low_d = {low_q[WIDTH-2:0], div_ge};
      end else begin
        acc_d = mul_sum[WIDTH:1];
        low_d = {mul_sum[0], low_q[WIDTH-1:1]};
      end
    end else if (state_q == FIX) begin
      if (div_q) begin
        lo_d  = neg_lo_q ? -low_q : low_q;
        hi_d  = neg_hi_q ? -acc_q : acc_q;
        dbz_d = (b_q == '0);
      end else begin
        {hi_d, lo_d} = prod_fix;
        dbz_d        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: reset, mul/div vectors,
// ignored requests, reset abort and back-to-back operation.
module tb_mult_div_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t mv [5] = '{
    '{2'd0, 32'd18, 32'd7, 32'd0, 32'd126, 1'b0},
    '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
      32'hFFFFFFFE, 32'h00000001, 1'b0},
    '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
      32'h0, 32'h1, 1'b0},
    '{2'd1, 32'hFFFFFFFD, 32'd5,
      32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0},
    '{2'd1, 32'h80000000, 32'h80000000,
      32'h40000000, 32'h0, 1'b0}
  };

  vec_t dv [8] = '{
    '{2'd2, 32'd18, 32'd7, 32'd4, 32'd2, 1'b0},
    '{2'd3, 32'hFFFFFFEE, 32'd7,
      32'hFFFFFFFC, 32'hFFFFFFFE, 1'b0},
    '{2'd3, 32'd18, 32'hFFFFFFF9,
      32'd4, 32'hFFFFFFFE, 1'b0},
    '{2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1},
    '{2'd3, 32'h80000000, 32'hFFFFFFFF,
      32'h0, 32'h80000000, 1'b0},
    '{2'd3, 32'hFFFFFFFB, 32'd0,
      32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1},
    '{2'd2, 32'hFFFFFFFF, 32'd16,
      32'hF, 32'h0FFFFFFF, 1'b0},
    '{2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0}
  };

  task automatic start_op(input logic [1:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int base, output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = base + i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy);
    end
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++; $display("FAIL rst_done: got %b want 0", bus.done);
    end
    n_cmp++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_hilo: got %h/%h want 0/0", bus.hi, bus.lo);
    end
    n_cmp++;
    if (bus.dbz !== 1'b0) begin
      n_bad++; $display("FAIL rst_dbz: got %b want 0", bus.dbz);
    end
  endtask

  task automatic test_first_start;
    int lat;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.op_a  = 32'd18;
    bus.op_b  = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL first_busy: got %b want 1", bus.busy);
    end
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 33) begin
      n_bad++; $display("FAIL first_lat: got %0d want 33", lat);
    end
    n_cmp++;
    if (bus.lo !== 32'd126 || bus.hi !== 32'd0) begin
      n_bad++;
      $display("FAIL first_res: got %h/%h want 0/7e", bus.hi, bus.lo);
    end
  endtask

  task automatic test_mul;
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(mv[i].op, mv[i].a, mv[i].b);
      wait_done(0, lat);
      n_cmp++;
      if (lat !== 33 || bus.hi !== mv[i].hi ||
          bus.lo !== mv[i].lo || bus.dbz !== mv[i].dbz) begin
        n_bad++;
        $display("FAIL mul[%0d]: got lat=%0d %h/%h dbz=%b want 33 %h/%h dbz=%b",
                 i, lat, bus.hi, bus.lo, bus.dbz,
                 mv[i].hi, mv[i].lo, mv[i].dbz);
      end
    end
  endtask

  task automatic test_div;
    int lat;
    for (int i = 0; i < 8; i++) begin
      start_op(dv[i].op, dv[i].a, dv[i].b);
      wait_done(0, lat);
      n_cmp++;
      if (lat !== 33 || bus.hi !== dv[i].hi ||
          bus.lo !== dv[i].lo || bus.dbz !== dv[i].dbz) begin
        n_bad++;
        $display("FAIL div[%0d]: got lat=%0d %h/%h dbz=%b want 33 %h/%h dbz=%b",
                 i, lat, bus.hi, bus.lo, bus.dbz,
                 dv[i].hi, dv[i].lo, dv[i].dbz);
      end
    end
  endtask

  task automatic test_ignore_hold;
    int lat;
    start_op(2'd0, 32'd3, 32'd4);
    wait_done(0, lat);
    start_op(2'd0, 32'd18, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd2;
    bus.op_a  = 32'd99;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL ign_busy: got %b want 1", bus.busy);
    end
    n_cmp++;
    if (bus.lo !== 32'd12 || bus.hi !== 32'd0) begin
      n_bad++;
      $display("FAIL hold_mid: got %h/%h want 0/c", bus.hi, bus.lo);
    end
    wait_done(10, lat);
    n_cmp++;
    if (lat !== 33 || bus.lo !== 32'd126 || bus.hi !== 32'd0) begin
      n_bad++;
      $display("FAIL ign_res: got lat=%0d %h/%h want 33 0/7e",
               lat, bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    start_op(2'd0, 32'd5, 32'd5);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_st: got busy=%b done=%b want 0/0",
               bus.busy, bus.done);
    end
    n_cmp++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      n_bad++;
      $display("FAIL abort_hilo: got %h/%h want 0/0", bus.hi, bus.lo);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL abort_done: got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(2'd0, 32'd5, 32'd6);
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 33 || bus.lo !== 32'd30) begin
      n_bad++;
      $display("FAIL b2b_first: got lat=%0d lo=%0d want 33 30", lat, bus.lo);
    end
    start_op(2'd0, 32'd3, 32'd4);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: got done=%b busy=%b want 0/1",
               bus.done, bus.busy);
    end
    n_cmp++;
    if (bus.lo !== 32'd30) begin
      n_bad++; $display("FAIL b2b_hold: got lo=%0d want 30", bus.lo);
    end
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 33 || bus.lo !== 32'd12 || bus.hi !== 32'd0) begin
      n_bad++;
      $display("FAIL b2b_second: got lat=%0d %h/%h want 33 0/c",
               lat, bus.hi, bus.lo);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++; $display("FAIL done_pulse: got %b want 0", bus.done);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.op_a  = 32'd0;
    bus.op_b  = 32'd0;
    test_reset();
    test_first_start();
    test_mul();
    test_div();
    test_ignore_hold();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; iteration count = WIDTH.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
REQ-006 op_a  input  WIDTH  multiplicand/dividend, driven from register-file port doa; sampled with start.
REQ-007 op_b  input  WIDTH  multiplier/divisor, driven from register-file port dob; sampled with start.
REQ-008 busy  output  1  operation in progress.
REQ-009 done  output  1  one-cycle pulse; hi/lo valid.
REQ-010 hi  output  WIDTH  product upper half / remainder.
REQ-011 lo  output  WIDTH  product lower half / quotient.
REQ-012 dbz  output  1  last division had divisor zero; held until next accepted start.

Function
REQ-013 States: IDLE, CALC, FIX, DONE; reset state IDLE.
REQ-014 IDLE or DONE with start=1: capture op, operand magnitudes (abs value for signed ops), and result sign flags; clear iteration counter; go to CALC; clear dbz.
REQ-015 IDLE with start=0: stay IDLE; DONE with start=0: go to IDLE.
REQ-016 CALC: one radix-2 step per clock (multiply: shift-add; divide: restoring shift-subtract); counter increments; after step WIDTH-1, go to FIX.
REQ-017 FIX: apply sign correction, write hi/lo/dbz, go to DONE.
REQ-018 busy=1 in CALC and FIX; 0 in IDLE and DONE.
REQ-019 done=1 only in DONE.
REQ-020 Latency: done high in the cycle after edge N+WIDTH+1, where edge N sampled start (WIDTH=32: 33 edges).
REQ-021 hi/lo change only on the FIX->DONE edge or reset; held unchanged otherwise, including through a new operation until its FIX.
REQ-022 start while busy=1 ignored; op, op_a, and op_b changes after capture ignored.
REQ-023 Back-to-back: start during DONE accepted; done deasserts the next cycle.
REQ-024 MULTU: {hi,lo} = unsigned op_a * op_b, full 2*WIDTH bits.
REQ-025 MULT: {hi,lo} = two's-complement product, full 2*WIDTH bits.
REQ-026 DIVU: lo = floor(op_a/op_b), hi = op_a mod op_b.
REQ-027 DIV: quotient truncated toward zero; remainder takes dividend's sign; |hi| < |op_b|.
REQ-028 DIV with op_a = most-negative and op_b = -1: lo = most-negative (0x80000000), hi = 0, dbz = 0.
REQ-029 Divide by zero (DIVU/DIV, op_b=0): same latency, lo = all ones, hi = op_a, dbz = 1.
REQ-030 Multiply ops leave dbz = 0.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, busy=0, done=0, hi=0, lo=0, dbz=0, counter=0; overrides start.
REQ-032 Reset mid-operation aborts it; no done pulse for the aborted operation; hi/lo read 0.
REQ-033 First start is accepted on the first edge with rst=0.

Verification
REQ-034 MULTU op_a=18 op_b=7 -> done at edge 33 after start; hi=0, lo=126, dbz=0.
REQ-035 DIVU 18/7 -> lo=2, hi=4; DIV -18/7 -> lo=0xFFFFFFFE, hi=0xFFFFFFFC.
REQ-036 0xFFFFFFFF*0xFFFFFFFF: MULTU -> hi=0xFFFFFFFE, lo=0x00000001; MULT -> hi=0, lo=1.
REQ-037 DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, dbz=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, dbz=0.
REQ-038 Start MULTU 18*7; pulse start (op DIVU) and change op_a at edge 10 -> ignored, result 126 at edge 33; rst at edge 20 of a second operation -> busy=0, no done, hi=lo=0.
REQ-039 Start asserted during DONE with 3*4 -> accepted; done one cycle only; second done 33 edges later with lo=12.
